lsu_dccm_bank_ctl: RTL and testbench



---
 rtl/lsu_dccm_pkg.sv | 26 ++
 rtl/lsu_dccm_wq.sv | 71 +++++++
 rtl/lsu_dccm_bank_ctl.sv | 160 ++++++++++++++++
 tb/tb_lsu_dccm_bank_ctl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dccm_pkg.sv
// Shared types, widths and address helpers for the banked DCCM port controller.
package lsu_dccm_pkg;

  localparam int DCCM_ADDR_W  = 16;
  localparam int DCCM_DATA_W  = 32;
  localparam int DCCM_ECC_W   = 7;
  localparam int DCCM_FDATA_W = DCCM_DATA_W + DCCM_ECC_W;

  // One pending store-buffer write: row-aligned address plus {ecc, data}.
  typedef struct packed {
    logic [DCCM_ADDR_W-1:0]  addr;
    logic [DCCM_FDATA_W-1:0] fdata;
  } wq_entry_t;

  // Bank index: the bits just above the byte-in-row offset.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int wb,
                                          input int nbanks);
    return (addr >> wb) & 32'(nbanks - 1);
  endfunction

  // Row identity: everything above the byte-in-row offset.
  function automatic logic [31:0] row_of(input logic [31:0] addr, input int wb);
    return addr >> wb;
  endfunction

endpackage

// File: rtl/lsu_dccm_wq.sv
// Write-drain FIFO; exposes per-entry row matches against the current load.
module lsu_dccm_wq
  import lsu_dccm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WB    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wq_entry_t        push_entry,
  input  logic             pop,
  input  logic [31:0]      lo_row,
  input  logic [31:0]      hi_row,
  output wq_entry_t        head,
  output logic             empty,
  output logic             full,
  output logic [DEPTH-1:0] row_match
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wq_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid, valid_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy: set the slot being pushed, clear the slot being popped.
  always_comb begin
    valid_nxt = valid;
    if (push) valid_nxt[wr_ptr] = 1'b1;
    if (pop)  valid_nxt[rd_ptr] = 1'b0;
  end

  // Pointer and occupancy registers.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      valid <= valid_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Entry storage.
  // NOTE: payload storage is deliberately not reset; the valid bits qualify every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Row match of every live entry against both rows touched by the load.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      row_match[i] = valid[i] &&
                     ((row_of(32'(mem[i].addr), WB) == lo_row) ||
                      (row_of(32'(mem[i].addr), WB) == hi_row));
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = ~|valid;
  assign full  = &valid;

endmodule

// File: rtl/lsu_dccm_bank_ctl.sv
// N-bank DCCM port controller: load issue, write-drain arbitration, read return.
module lsu_dccm_bank_ctl
  import lsu_dccm_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_W     = DCCM_DATA_W,
  parameter int ECC_W      = DCCM_ECC_W,
  parameter int ADDR_W     = DCCM_ADDR_W,
  parameter int WQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3,
  parameter int RD_LAT     = 1,
  localparam int FDATA_W   = DATA_W + ECC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze_i,
  input  logic                           ld_valid_i,
  output logic                           ld_ready_o,
  input  logic [ADDR_W-1:0]              ld_addr_lo_i,
  input  logic [ADDR_W-1:0]              ld_addr_hi_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [ADDR_W-1:0]              wr_addr_i,
  input  logic [FDATA_W-1:0]             wr_data_i,
  output logic                           wq_empty_o,
  output logic [NUM_BANKS-1:0]           bank_rden_o,
  output logic [NUM_BANKS*ADDR_W-1:0]    bank_rd_addr_o,
  output logic [NUM_BANKS-1:0]           bank_wren_o,
  output logic [ADDR_W-1:0]              bank_wr_addr_o,
  output logic [FDATA_W-1:0]             bank_wr_data_o,
  input  logic [NUM_BANKS*FDATA_W-1:0]   bank_rd_data_i,
  output logic                           rd_valid_o,
  output logic [FDATA_W-1:0]             rd_data_lo_o,
  output logic [FDATA_W-1:0]             rd_data_hi_o
);

  localparam int WB        = $clog2(DATA_W / 8);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int CNT_W     = $clog2(STARVE_MAX + 1);

  logic [BANK_BITS-1:0] lo_bank, hi_bank, head_bank;
  logic [31:0]          lo_row, hi_row;
  wq_entry_t            push_entry, head;
  logic [WQ_DEPTH-1:0]  row_match;
  logic                 wq_empty, wq_full, push, issue;
  logic                 row_hit, starve_force, ld_accept, conflict;
  logic [CNT_W-1:0]     defer_cnt;

  assign lo_bank   = BANK_BITS'(bank_of(32'(ld_addr_lo_i), WB, NUM_BANKS));
  assign hi_bank   = BANK_BITS'(bank_of(32'(ld_addr_hi_i), WB, NUM_BANKS));
  assign head_bank = BANK_BITS'(bank_of(32'(head.addr), WB, NUM_BANKS));
  assign lo_row    = row_of(32'(ld_addr_lo_i), WB);
  assign hi_row    = row_of(32'(ld_addr_hi_i), WB);

  assign push_entry = '{addr: wr_addr_i, fdata: wr_data_i};
  assign push       = wr_valid_i & ~wq_full;

  lsu_dccm_wq #(
    .DEPTH (WQ_DEPTH),
    .WB    (WB)
  ) u_wq (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (issue),
    .lo_row     (lo_row),
    .hi_row     (hi_row),
    .head       (head),
    .empty      (wq_empty),
    .full       (wq_full),
    .row_match  (row_match)
  );

  // A load touching a queued row waits so it never reads stale data; the
  // starvation guard steals one load slot so the head write is guaranteed out.
  assign row_hit      = |row_match;
  assign starve_force = ~wq_empty & ~freeze_i & (defer_cnt == CNT_W'(STARVE_MAX));
  assign ld_ready_o   = ~rst & ~freeze_i & ~row_hit & ~starve_force;
  assign ld_accept    = ld_valid_i & ld_ready_o;
  assign conflict     = ld_accept & ~wq_empty &
                        ((head_bank == lo_bank) || (head_bank == hi_bank));
  assign issue        = ~wq_empty & ~freeze_i & ~conflict;

  // Consecutive deferrals of the head write; saturates and holds under freeze.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      defer_cnt <= '0;
    end else if (issue) begin
      defer_cnt <= '0;
    end else if (conflict && (defer_cnt != CNT_W'(STARVE_MAX))) begin
      defer_cnt <= defer_cnt + 1'b1;
    end
  end

  // Per-bank read/write strobes and read addresses.
  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    bank_rden_o = '0;
    bank_wren_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_rd_addr_o[b*ADDR_W +: ADDR_W] =
        (BANK_BITS'(b) == lo_bank) ? ld_addr_lo_i : ld_addr_hi_i;
    end
    if (ld_accept) begin
      bank_rden_o[lo_bank] = 1'b1;
      bank_rden_o[hi_bank] = 1'b1;
    end
    if (issue) bank_wren_o[head_bank] = 1'b1;
  end

  assign bank_wr_addr_o = head.addr;
  assign bank_wr_data_o = head.fdata;
  assign wr_ready_o     = ~wq_full;
  assign wq_empty_o     = wq_empty;

  logic                 s1_valid;
  logic [BANK_BITS-1:0] s1_lo_bank, s1_hi_bank;
  logic [FDATA_W-1:0]   lo_mux, hi_mux;

  // First return stage: remember which banks the accepted load hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_lo_bank <= '0;
      s1_hi_bank <= '0;
    end else begin
      s1_valid <= ld_accept;
      if (ld_accept) begin
        s1_lo_bank <= lo_bank;
        s1_hi_bank <= hi_bank;
      end
    end
  end

  assign lo_mux = bank_rd_data_i[s1_lo_bank*FDATA_W +: FDATA_W];
  assign hi_mux = bank_rd_data_i[s1_hi_bank*FDATA_W +: FDATA_W];

  if (RD_LAT == 1) begin : g_rd_lat1
    assign rd_valid_o   = s1_valid;
    assign rd_data_lo_o = lo_mux;
    assign rd_data_hi_o = hi_mux;
  end else begin : g_rd_lat2
    // Optional output register stage for timing closure on the SRAM data path.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_o   <= 1'b0;
        rd_data_lo_o <= '0;
        rd_data_hi_o <= '0;
      end else begin
        rd_valid_o <= s1_valid;
        if (s1_valid) begin
          rd_data_lo_o <= lo_mux;
          rd_data_hi_o <= hi_mux;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_dccm_bank_ctl.sv
// Self-checking bench for lsu_dccm_bank_ctl (default configuration, RD_LAT=1).
module tb_lsu_dccm_bank_ctl;

  localparam int NB = 4;
  localparam int AW = 16;
  localparam int FW = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, freeze, ld_valid, wr_valid;
  logic [AW-1:0]     ld_addr_lo, ld_addr_hi, wr_addr;
  logic [FW-1:0]     wr_data;
  logic              ld_ready_o, wr_ready_o, wq_empty_o, rd_valid_o;
  logic [NB-1:0]     bank_rden_o, bank_wren_o;
  logic [NB*AW-1:0]  bank_rd_addr_o;
  logic [AW-1:0]     bank_wr_addr_o;
  logic [FW-1:0]     bank_wr_data_o, rd_data_lo_o, rd_data_hi_o;
  logic [NB*FW-1:0]  bank_rd_data;
  logic [FW-1:0]     sram_q [NB];

  lsu_dccm_bank_ctl #(
    .NUM_BANKS(NB), .DATA_W(32), .ECC_W(7), .ADDR_W(AW),
    .WQ_DEPTH(4), .STARVE_MAX(3), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .freeze_i(freeze),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready_o),
    .ld_addr_lo_i(ld_addr_lo), .ld_addr_hi_i(ld_addr_hi),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wq_empty_o(wq_empty_o),
    .bank_rden_o(bank_rden_o), .bank_rd_addr_o(bank_rd_addr_o),
    .bank_wren_o(bank_wren_o), .bank_wr_addr_o(bank_wr_addr_o),
    .bank_wr_data_o(bank_wr_data_o), .bank_rd_data_i(bank_rd_data),
    .rd_valid_o(rd_valid_o), .rd_data_lo_o(rd_data_lo_o), .rd_data_hi_o(rd_data_hi_o)
  );

  // Content of a bank row: depends on the bank and the row, not the byte offset.
  function automatic logic [FW-1:0] pat(input int b, input logic [AW-1:0] a);
    logic [6:0]  e;
    logic [15:0] tag;
    e   = 7'(b) ^ 7'h5A;
    tag = 16'(b + 1) * 16'h1111;
    return {e, tag, 2'b10, a[15:2]};
  endfunction

  function automatic int bank(input logic [AW-1:0] a);
    return int'(a[3:2]);
  endfunction

  // SRAM model: data one cycle after the read enable.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (bank_rden_o[b]) sram_q[b] <= pat(b, bank_rd_addr_o[b*AW +: AW]);
  end
  assign bank_rd_data = {sram_q[3], sram_q[2], sram_q[1], sram_q[0]};

  typedef struct { logic [FW-1:0] lo; logic [FW-1:0] hi; } rd_exp_t;
  typedef struct { logic [NB-1:0] wren; logic [AW-1:0] addr; logic [FW-1:0] data; } wr_exp_t;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int vectors = 0;
  int miscompares = 0;

  // One cycle: score returned reads / issued writes, record handshakes, advance.
  task automatic tick();
    rd_exp_t re;
    wr_exp_t we;
    #1;
    if (rd_valid_o !== 1'b0) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: rd_valid_o=%b with no load outstanding", rd_valid_o);
      end else begin
        re = rd_q.pop_front();
        if (rd_data_lo_o !== re.lo || rd_data_hi_o !== re.hi) begin
          miscompares++;
          $display("FAIL rd_data: lo=%h hi=%h expected lo=%h hi=%h",
                   rd_data_lo_o, rd_data_hi_o, re.lo, re.hi);
        end
      end
    end
    if (bank_wren_o !== '0) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: bank_wren_o=%b with no write queued", bank_wren_o);
      end else begin
        we = wr_q.pop_front();
        if (bank_wren_o !== we.wren || bank_wr_addr_o !== we.addr || bank_wr_data_o !== we.data) begin
          miscompares++;
          $display("FAIL wr_issue: wren=%b addr=%h data=%h expected wren=%b addr=%h data=%h",
                   bank_wren_o, bank_wr_addr_o, bank_wr_data_o, we.wren, we.addr, we.data);
        end
      end
    end
    if (ld_valid && ld_ready_o === 1'b1)
      rd_q.push_back('{lo: pat(bank(ld_addr_lo), ld_addr_lo), hi: pat(bank(ld_addr_hi), ld_addr_hi)});
    if (wr_valid && wr_ready_o === 1'b1)
      wr_q.push_back('{wren: NB'(1) << bank(wr_addr), addr: wr_addr, data: wr_data});
    @(negedge clk);
  endtask

  task automatic idle();
    ld_valid = 1'b0;
    wr_valid = 1'b0;
    freeze   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    ld_valid = 1'b1; ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0010;
    wr_addr = '0; wr_data = '0;
    @(negedge clk); #1;
    vectors++;
    if (ld_ready_o !== 1'b0 || bank_rden_o !== 4'b0000 || bank_wren_o !== 4'b0000 ||
        rd_valid_o !== 1'b0 || wr_ready_o !== 1'b1 || wq_empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: ld_ready=%b rden=%b wren=%b rd_valid=%b wr_ready=%b wq_empty=%b expected 0 0000 0000 0 1 1",
               ld_ready_o, bank_rden_o, bank_wren_o, rd_valid_o, wr_ready_o, wq_empty_o);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_single();
    ld_valid = 1'b1; ld_addr_lo = 16'h0010; ld_addr_hi = 16'h0010;
    #1;
    vectors++;
    if (ld_ready_o !== 1'b1 || bank_rden_o !== 4'b0001 || bank_rd_addr_o[0 +: AW] !== 16'h0010) begin
      miscompares++;
      $display("FAIL load_single_issue: ld_ready=%b rden=%b addr0=%h expected 1 0001 0010",
               ld_ready_o, bank_rden_o, bank_rd_addr_o[0 +: AW]);
    end
    tick();
    idle(); #1;
    vectors++;
    if (rd_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_single_latency: rd_valid=%b expected 1", rd_valid_o);
    end
    tick(); #1;
    vectors++;
    if (rd_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_single_pulse: rd_valid=%b expected 0", rd_valid_o);
    end
    tick();
  endtask

  task automatic test_load_unaligned();
    // lo 0x001E lives in bank 3, hi 0x0021 in bank 0.
    ld_valid = 1'b1; ld_addr_lo = 16'h001E; ld_addr_hi = 16'h0021;
    #1;
    vectors++;
    if (bank_rden_o !== 4'b1001 || bank_rd_addr_o[3*AW +: AW] !== 16'h001E ||
        bank_rd_addr_o[0 +: AW] !== 16'h0021) begin
      miscompares++;
      $display("FAIL load_unaligned_issue: rden=%b addr3=%h addr0=%h expected 1001 001e 0021",
               bank_rden_o, bank_rd_addr_o[3*AW +: AW], bank_rd_addr_o[0 +: AW]);
    end
    tick();
    idle(); #1;
    vectors++;
    if (rd_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_unaligned_return: rd_valid=%b expected 1", rd_valid_o);
    end
    tick(); tick();
  endtask

  task automatic test_write_concurrent();
    wr_valid = 1'b1; wr_addr = 16'h0008; wr_data = {7'h2A, 32'hCAFE_0008};
    #1;
    vectors++;
    if (wr_ready_o !== 1'b1 || bank_wren_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL write_push: wr_ready=%b wren=%b expected 1 0000", wr_ready_o, bank_wren_o);
    end
    tick();
    wr_valid = 1'b0; ld_valid = 1'b1; ld_addr_lo = 16'h0000; ld_addr_hi = 16'h0000;
    #1;
    vectors++;
    if (ld_ready_o !== 1'b1 || bank_rden_o !== 4'b0001 || bank_wren_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL write_concurrent: ld_ready=%b rden=%b wren=%b expected 1 0001 0100",
               ld_ready_o, bank_rden_o, bank_wren_o);
    end
    tick();
    idle(); tick(); #1;
    vectors++;
    if (wq_empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL write_drained: wq_empty=%b expected 1", wq_empty_o);
    end
    tick();
  endtask

  task automatic test_starve();
    wr_valid = 1'b1; wr_addr = 16'h0004; wr_data = {7'h11, 32'hBEEF_0004};
    tick();
    wr_valid = 1'b0; ld_valid = 1'b1; ld_addr_lo = 16'h0014; ld_addr_hi = 16'h0014;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (ld_ready_o !== 1'b1 || bank_wren_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL starve_defer%0d: ld_ready=%b wren=%b expected 1 0000", i, ld_ready_o, bank_wren_o);
      end
      tick();
    end
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (ld_ready_o !== 1'b0 || bank_rden_o !== 4'b0000 || bank_wren_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL starve_freeze%0d: ld_ready=%b rden=%b wren=%b expected 0 0000 0000",
                 i, ld_ready_o, bank_rden_o, bank_wren_o);
      end
      tick();
    end
    freeze = 1'b0; #1;
    vectors++;
    if (ld_ready_o !== 1'b1 || bank_wren_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL starve_defer2: ld_ready=%b wren=%b expected 1 0000", ld_ready_o, bank_wren_o);
    end
    tick(); #1;
    vectors++;
    if (ld_ready_o !== 1'b0 || bank_wren_o !== 4'b0010 || bank_rden_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL starve_force: ld_ready=%b wren=%b rden=%b expected 0 0010 0000",
               ld_ready_o, bank_wren_o, bank_rden_o);
    end
    tick(); #1;
    vectors++;
    if (ld_ready_o !== 1'b1 || bank_wren_o !== 4'b0000 || wq_empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_after: ld_ready=%b wren=%b wq_empty=%b expected 1 0000 1",
               ld_ready_o, bank_wren_o, wq_empty_o);
    end
    tick();
    idle(); tick(); tick();
  endtask

  task automatic test_row_hit_and_full();
    wr_valid = 1'b1; wr_addr = 16'h0040; wr_data = {7'h33, 32'h1234_0040};
    tick();
    wr_valid = 1'b0; ld_valid = 1'b1; ld_addr_lo = 16'h0042; ld_addr_hi = 16'h0042;
    #1;
    vectors++;
    if (ld_ready_o !== 1'b0 || bank_wren_o !== 4'b0001) begin
      miscompares++;
      $display("FAIL row_hit_stall: ld_ready=%b wren=%b expected 0 0001", ld_ready_o, bank_wren_o);
    end
    tick(); #1;
    vectors++;
    if (ld_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL row_hit_release: ld_ready=%b expected 1", ld_ready_o);
    end
    tick();
    idle(); tick(); tick();
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = 16'(32'h0080 + i * 4); wr_data = {7'(i), 32'hF000_0000 + 32'(i)};
      #1;
      vectors++;
      if (wr_ready_o !== (i < 4)) begin
        miscompares++;
        $display("FAIL fill%0d: wr_ready=%b expected %b", i, wr_ready_o, (i < 4));
      end
      tick();
    end
    freeze = 1'b0; #1;
    vectors++;
    if (wr_ready_o !== 1'b0 || bank_wren_o !== 4'b0001 || wq_empty_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_same_cycle: wr_ready=%b wren=%b wq_empty=%b expected 0 0001 0",
               wr_ready_o, bank_wren_o, wq_empty_o);
    end
    tick(); #1;
    vectors++;
    if (wr_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL full_after_pop: wr_ready=%b expected 1", wr_ready_o);
    end
    tick();
    wr_valid = 1'b0;
    for (int n = 0; n < 20 && wq_empty_o !== 1'b1; n++) tick();
    vectors++;
    if (wq_empty_o !== 1'b1 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: wq_empty=%b pending=%0d expected 1 0", wq_empty_o, wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr_lo = 16'(32'h0100 + i * 8);
      ld_addr_hi = 16'(32'h0101 + i * 8);
      #1;
      if (i > 0) begin
        vectors++;
        if (rd_valid_o !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_return%0d: rd_valid=%b expected 1", i, rd_valid_o);
        end
      end
      tick();
    end
    idle(); tick(); #1;
    vectors++;
    if (rd_valid_o !== 1'b0 || rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end: rd_valid=%b pending=%0d expected 0 0", rd_valid_o, rd_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    freeze = 1'b1;
    wr_valid = 1'b1; wr_addr = 16'h0104; wr_data = {7'h44, 32'hAAAA_0104};
    tick();
    wr_addr = 16'h0204; wr_data = {7'h55, 32'hBBBB_0204};
    tick();
    freeze = 1'b0; wr_valid = 1'b0;
    ld_valid = 1'b1; ld_addr_lo = 16'h0014; ld_addr_hi = 16'h0014;
    #1;
    vectors++;
    if (ld_ready_o !== 1'b1 || bank_wren_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_setup: ld_ready=%b wren=%b expected 1 0000", ld_ready_o, bank_wren_o);
    end
    tick();
    rst = 1'b1; idle();
    #1;
    vectors++;
    if (rd_valid_o !== 1'b0 || bank_wren_o !== 4'b0000 || wq_empty_o !== 1'b1 ||
        ld_ready_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid: rd_valid=%b wren=%b wq_empty=%b ld_ready=%b wr_ready=%b expected 0 0000 1 0 1",
               rd_valid_o, bank_wren_o, wq_empty_o, ld_ready_o, wr_ready_o);
    end
    rd_q.delete();
    wr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (wq_empty_o !== 1'b1 || ld_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_after: wq_empty=%b ld_ready=%b expected 1 1", wq_empty_o, ld_ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_single();
    test_load_unaligned();
    test_write_concurrent();
    test_starve();
    test_row_hit_and_full();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: reads=%0d writes=%0d expected 0 0", rd_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
